change_dispenser: RTL and testbench

//  Consumer side of the vending machine's payout interface: takes a change amount
//  (rupees) once a drink is dispensed and pays it out as 3-rupee and 1-rupee coins.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/coin_inventory.sv | 27 ++
 rtl/change_dispenser.sv | 168 ++++++++++++++++
 tb/tb_change_dispenser.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared FSM states, coin selection and coin value constants for the change dispenser
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    PULSE    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  typedef enum logic {
    SEL_HI = 1'b0,
    SEL_LO = 1'b1
  } coin_t;

  localparam int COIN_HI_DEF = 3;
  localparam int COIN_LO_VAL = 1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - one saturating up/down coin counter with a parameterised reset value
module coin_inventory #(
  parameter int W    = 4,
  parameter int INIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V  = '1;
  localparam logic [W-1:0] INIT_V = W'(INIT);

  // Simultaneous refill and payout cancel out instead of racing each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= INIT_V;
    end else if (inc && !dec) begin
      if (count != MAX_V) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 3/1-rupee change payout FSM driving a coin hopper; CHANGE_DISP_STATS_EN enables the coins_total counter
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int COIN_HI     = COIN_HI_DEF,
  parameter int INV_W       = 4,
  parameter int INIT_HI     = 8,
  parameter int INIT_LO     = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             eject_hi,
  output logic             eject_lo,
  input  logic             hopper_ack,
  input  logic             refill_hi,
  input  logic             refill_lo,
  input  logic             fault_clr,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic             fault,
  output logic [INV_W-1:0] inv_hi,
  output logic [INV_W-1:0] inv_lo,
  output logic [7:0]       coins_total
);

  localparam int                 CNT_W  = cnt_width(ACK_TIMEOUT);
  localparam logic [AMT_W-1:0]   HI_VAL = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0]   LO_VAL = AMT_W'(COIN_LO_VAL);
  localparam logic [CNT_W-1:0]   TMO_V  = CNT_W'(ACK_TIMEOUT);

  state_t             state, state_nxt;
  coin_t              sel, sel_nxt;
  logic [AMT_W-1:0]   remaining, remaining_nxt;
  logic [CNT_W-1:0]   tmo_cnt, tmo_nxt;
  logic               ack_take;
  logic               dec_hi, dec_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= SEL_HI;
      remaining <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      remaining <= remaining_nxt;
      tmo_cnt   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    remaining_nxt = remaining;
    tmo_nxt       = tmo_cnt;
    req_ready     = 1'b0;
    eject_hi      = 1'b0;
    eject_lo      = 1'b0;
    done          = 1'b0;
    shortfall     = '0;
    fault         = 1'b0;
    ack_take      = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          remaining_nxt = req_amount;
          state_nxt     = SELECT;
        end
      end

      SELECT: begin
        tmo_nxt = '0;
        // Greedy choice; a coin is only picked when it cannot overpay.
        if (remaining >= HI_VAL && inv_hi != '0) begin
          sel_nxt   = SEL_HI;
          state_nxt = PULSE;
        end else if (remaining >= LO_VAL && inv_lo != '0) begin
          sel_nxt   = SEL_LO;
          state_nxt = PULSE;
        end else begin
          state_nxt = DONE;
        end
      end

      PULSE: begin
        eject_hi  = (sel == SEL_HI);
        eject_lo  = (sel == SEL_LO);
        state_nxt = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (hopper_ack) begin
          ack_take      = 1'b1;
          remaining_nxt = remaining - ((sel == SEL_HI) ? HI_VAL : LO_VAL);
          tmo_nxt       = '0;
          state_nxt     = SELECT;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
          if (tmo_nxt == TMO_V) state_nxt = FAULT;
        end
      end

      DONE: begin
        done          = 1'b1;
        shortfall     = remaining;
        remaining_nxt = '0;
        state_nxt     = IDLE;
      end

      FAULT: begin
        fault = 1'b1;
        if (fault_clr) begin
          remaining_nxt = '0;
          tmo_nxt       = '0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign dec_hi = ack_take && (sel == SEL_HI);
  assign dec_lo = ack_take && (sel == SEL_LO);

  coin_inventory #(
    .W    (INV_W),
    .INIT (INIT_HI)
  ) u_inv_hi (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_hi),
    .dec   (dec_hi),
    .count (inv_hi)
  );

  coin_inventory #(
    .W    (INV_W),
    .INIT (INIT_LO)
  ) u_inv_lo (
    .clk   (clk),
    .reset (reset),
    .inc   (refill_lo),
    .dec   (dec_lo),
    .count (inv_lo)
  );

`ifdef CHANGE_DISP_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coins_total <= '0;
    end else if (ack_take && coins_total != 8'hFF) begin
      coins_total <= coins_total + 8'd1;
    end
  end
`else
  assign coins_total = '0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser: payouts, shortfall, timeout fault, refill and reset
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_amount = '0;
  logic       req_ready;
  logic       eject_hi, eject_lo;
  logic       hopper_ack = 1'b0;
  logic       refill_hi = 1'b0;
  logic       refill_lo = 1'b0;
  logic       fault_clr = 1'b0;
  logic       done;
  logic [3:0] shortfall;
  logic       fault;
  logic [3:0] inv_hi, inv_lo;
  logic [7:0] coins_total;

  change_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .eject_hi    (eject_hi),
    .eject_lo    (eject_lo),
    .hopper_ack  (hopper_ack),
    .refill_hi   (refill_hi),
    .refill_lo   (refill_lo),
    .fault_clr   (fault_clr),
    .done        (done),
    .shortfall   (shortfall),
    .fault       (fault),
    .inv_hi      (inv_hi),
    .inv_lo      (inv_lo),
    .coins_total (coins_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int mhi = 8;
  int mlo = 8;
  int mcoins = 0;
  logic coin_q[$];
  logic [3:0] short_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_coins();
`ifdef CHANGE_DISP_STATS_EN
    return (mcoins > 255) ? 255 : mcoins;
`else
    return 0;
`endif
  endfunction

  task automatic refill(input bit hi, input int n);
    repeat (n) begin
      @(negedge clk);
      if (hi) begin refill_hi = 1'b1; if (mhi < 15) mhi++; end
      else    begin refill_lo = 1'b1; if (mlo < 15) mlo++; end
      @(negedge clk);
      refill_hi = 1'b0;
      refill_lo = 1'b0;
    end
  endtask

  task automatic run_req(input logic [3:0] amt, input bit refill_ack);
    int  rem;
    int  cyc;
    bit  got_done;
    logic c;
    logic [3:0] es;
    rem = amt;
    while (1) begin
      if (rem >= 3 && mhi > 0) begin
        coin_q.push_back(1'b1);
        if (!refill_ack) mhi--;
        rem -= 3;
        mcoins++;
      end else if (rem >= 1 && mlo > 0) begin
        coin_q.push_back(1'b0);
        mlo--;
        rem -= 1;
        mcoins++;
      end else begin
        break;
      end
    end
    short_q.push_back(4'(rem));

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_amount = amt;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    got_done = 0;
    repeat (200) begin
      if (eject_hi || eject_lo) begin
        check("eject_one_hot", eject_hi & eject_lo, 0);
        if (coin_q.size() == 0) begin
          check("extra_eject", 1, 0);
        end else begin
          c = coin_q.pop_front();
          check("eject_coin_hi", eject_hi, c);
        end
        @(negedge clk);
        hopper_ack = 1'b1;
        refill_hi  = refill_ack;
        @(negedge clk);
        hopper_ack = 1'b0;
        refill_hi  = 1'b0;
        cyc += 2;
      end else if (done) begin
        es = short_q.pop_front();
        check("shortfall", shortfall, es);
        if (amt == 0) check("done_latency", cyc, 2);
        got_done = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", got_done, 1);
    check("coins_left", coin_q.size(), 0);
    @(negedge clk);
    check("done_pulse_1cyc", done, 0);
    check("shortfall_idle", shortfall, 0);
    check("inv_hi", inv_hi, mhi);
    check("inv_lo", inv_lo, mlo);
    check("coins_total", coins_total, exp_coins());
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", req_ready, 1);
    check("rst_eject", {eject_hi, eject_lo}, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_shortfall", shortfall, 0);
    check("rst_inv_hi", inv_hi, 8);
    check("rst_inv_lo", inv_lo, 8);
    check("rst_coins", coins_total, 0);
  endtask

  initial begin
    int k;
    bit seen;
    #12;
    check_reset_state();
    @(negedge clk);
    reset = 1'b1;

    run_req(4'd7, 1'b0);   // hi, hi, lo -> 6/7
    run_req(4'd15, 1'b0);  // 5 hi -> 1/7
    run_req(4'd9, 1'b0);   // 1 hi + 6 lo -> 0/1
    refill(1'b0, 1);       // 0/2
    run_req(4'd5, 1'b0);   // lo x2, shortfall 3 -> 0/0
    run_req(4'd0, 1'b0);   // no coins, latency check
    run_req(4'd4, 1'b0);   // empty inventory, shortfall 4

    refill(1'b0, 16);
    @(negedge clk);
    check("inv_lo_saturate", inv_lo, 15);
    refill(1'b1, 2);
    run_req(4'd3, 1'b1);   // refill_hi with hi ack -> inv_hi stays 2

    // Hopper never acknowledges: expect FAULT after the timeout.
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      if (!seen && eject_hi) seen = 1;
      if (!seen) @(negedge clk);
    end
    check("fault_eject_seen", seen, 1);
    k = 0;
    repeat (40) begin
      if (!fault) begin
        @(negedge clk);
        k++;
      end
    end
    check("fault_latency", k, 16);
    check("fault_flag", fault, 1);
    check("fault_req_ready", req_ready, 0);
    check("fault_no_eject", {eject_hi, eject_lo}, 0);
    check("fault_inv_hi", inv_hi, mhi);
    repeat (3) @(negedge clk);
    check("fault_sticky", fault, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_req_ready", req_ready, 1);

    // Reset during WAIT_ACK.
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      if (!seen && eject_hi) seen = 1;
      if (!seen) @(negedge clk);
    end
    check("rst_mid_eject_seen", seen, 1);
    @(negedge clk);
    check("rst_mid_busy", req_ready, 0);
    reset = 1'b0;
    #1;
    check_reset_state();
    mhi = 8;
    mlo = 8;
    mcoins = 0;
    @(negedge clk);
    reset = 1'b1;

    run_req(4'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
